// File: rtl/seven_seg_scan_pkg.sv
// Shared types and the active-low hex segment table for the seven_seg_scan display driver.
package sevseg_pkg;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit order {g,f,e,d,c,b,a}, a low bit lights the segment.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seven_seg_scan_if.sv
// Value-load and display-pin bundle between the digit-value logic and seven_seg_scan.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 2
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output load, digits_in,
        input  seg, an, digit_idx, frame_done
    );

    modport slave (
        input  load, digits_in,
        output seg, an, digit_idx, frame_done
    );

endinterface

// File: rtl/seven_seg_scan_hex_decode.sv
// Combinational 4-bit to active-low 7-segment decoder.
module seg_hex_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-atomic value updates.
// Optional SEVSEG_LEADING_ZERO_BLANK_EN suppresses digits above the most-significant nonzero one.
//
// state | meaning
// DEAD  | blanking dead-time at the start of a slot, all anodes off
// ON    | current digit enabled and its segments driven
module seven_seg_scan
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int SLOT_CYCLES = 64,
    parameter int DEAD_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    seven_seg_scan_if.slave scan
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(SLOT_CYCLES);
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]      pending_q, pending_d;
    logic [DATA_W-1:0]      display_q, display_d;
    logic [6:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic                   frame_done_q, frame_done_d;
    logic [3:0]             nibble;
    logic [6:0]             nibble_seg;
    logic                   digit_blank;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        pending_d    = scan.load ? scan.digits_in : pending_q;
        display_d    = display_q;
        case (state_q)
            DEAD: begin
                if (cnt_q == CNT_DEAD_LAST) state_d = ON;
            end
            ON: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DEAD;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        // Frame boundary: a load landing here is already folded into pending_d.
                        idx_d     = '0;
                        display_d = pending_d;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = DEAD;
        endcase
        frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    // Outputs are built from next-state values so the registered pins line up with state_q.
    always_comb begin
        nibble = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) nibble = display_d[4*k +: 4];
        end
    end

    seg_hex_decode u_hex_decode (
        .nibble_i (nibble),
        .seg_o    (nibble_seg)
    );

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        digit_blank = 1'b0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) digit_blank = ((display_d >> (4*k)) == '0);
        end
    end
`else
    assign digit_blank = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if ((state_d == ON) && !digit_blank) begin
            seg_d = nibble_seg;
            an_d  = ~(NUM_DIGITS'(1) << idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= DEAD;
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            display_q    <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            display_q    <= display_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign scan.seg        = seg_q;
    assign scan.an         = an_q;
    assign scan.digit_idx  = idx_q;
    assign scan.frame_done = frame_done_q;

endmodule
